// File: rtl/arm_mem_arbiter.sv
// arm_mem_arbiter: shares one arm_memory port between instruction fetch and load/store.
// Define ARM_MEM_ARB_FIXED_PRIO_EN for strict LS priority instead of round-robin.
module arm_mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_excpt,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_excpt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_we,
  input  logic              mem_excpt,
  input  logic [DATA_W-1:0] mem_data_out
);

  typedef enum logic {IDLE, ACCESS} state_e;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              ownerLs_q, ownerLs_d;
  logic              accWe_q, accWe_d;
  logic [ADDR_W-1:0] memAddr_q, memAddr_d;
  logic [DATA_W-1:0] memDataIn_q, memDataIn_d;
  logic              memWe_q, memWe_d;
  logic              ifGnt_q, ifGnt_d;
  logic              lsGnt_q, lsGnt_d;
  logic              ifRvalid_q, ifRvalid_d;
  logic              lsRvalid_q, lsRvalid_d;
  logic [DATA_W-1:0] ifRdata_q, ifRdata_d;
  logic [DATA_W-1:0] lsRdata_q, lsRdata_d;
  logic              ifExcpt_q, ifExcpt_d;
  logic              lsExcpt_q, lsExcpt_d;

  logic grant;
  logic pickLs;
  logic done;

  assign grant = (state_q == IDLE) && (if_req || ls_req);
  assign done  = (state_q == ACCESS) && (cnt_q == 4'd0);

`ifdef ARM_MEM_ARB_FIXED_PRIO_EN
  assign pickLs = ls_req;
`else
  // Pointer resets to "IF granted last" so LS wins the first tie.
  logic lastIsLs_q;

  assign pickLs = ls_req && (!if_req || !lastIsLs_q);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)
      lastIsLs_q <= 1'b0;
    else if (grant)
      lastIsLs_q <= pickLs;
  end
`endif

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      ownerLs_q   <= 1'b0;
      accWe_q     <= 1'b0;
      memAddr_q   <= '0;
      memDataIn_q <= '0;
      memWe_q     <= 1'b0;
      ifGnt_q     <= 1'b0;
      lsGnt_q     <= 1'b0;
      ifRvalid_q  <= 1'b0;
      lsRvalid_q  <= 1'b0;
      ifRdata_q   <= '0;
      lsRdata_q   <= '0;
      ifExcpt_q   <= 1'b0;
      lsExcpt_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ownerLs_q   <= ownerLs_d;
      accWe_q     <= accWe_d;
      memAddr_q   <= memAddr_d;
      memDataIn_q <= memDataIn_d;
      memWe_q     <= memWe_d;
      ifGnt_q     <= ifGnt_d;
      lsGnt_q     <= lsGnt_d;
      ifRvalid_q  <= ifRvalid_d;
      lsRvalid_q  <= lsRvalid_d;
      ifRdata_q   <= ifRdata_d;
      lsRdata_q   <= lsRdata_d;
      ifExcpt_q   <= ifExcpt_d;
      lsExcpt_q   <= lsExcpt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (grant) begin
          state_d = ACCESS;
          cnt_d   = LAT_M1;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0)
          state_d = IDLE;
        else
          cnt_d = cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // mem_addr/mem_data_in only move on a grant so the memory never sees stray addresses.
  always_comb begin
    ownerLs_d   = ownerLs_q;
    accWe_d     = accWe_q;
    memAddr_d   = memAddr_q;
    memDataIn_d = memDataIn_q;
    memWe_d     = 1'b0;
    ifGnt_d     = 1'b0;
    lsGnt_d     = 1'b0;
    ifRvalid_d  = 1'b0;
    lsRvalid_d  = 1'b0;
    ifRdata_d   = ifRdata_q;
    lsRdata_d   = lsRdata_q;
    ifExcpt_d   = ifExcpt_q;
    lsExcpt_d   = lsExcpt_q;
    if (grant) begin
      ownerLs_d = pickLs;
      accWe_d   = pickLs && ls_we;
      memWe_d   = pickLs && ls_we;
      lsGnt_d   = pickLs;
      ifGnt_d   = !pickLs;
      if (pickLs) begin
        memAddr_d   = ls_addr;
        memDataIn_d = ls_wdata;
      end else begin
        memAddr_d = if_addr;
      end
    end
    if (done) begin
      if (ownerLs_q) begin
        lsRvalid_d = 1'b1;
        lsRdata_d  = accWe_q ? '0 : mem_data_out;
        lsExcpt_d  = mem_excpt;
      end else begin
        ifRvalid_d = 1'b1;
        ifRdata_d  = mem_data_out;
        ifExcpt_d  = mem_excpt;
      end
    end
  end

  assign if_gnt      = ifGnt_q;
  assign if_rvalid   = ifRvalid_q;
  assign if_rdata    = ifRdata_q;
  assign if_excpt    = ifExcpt_q;
  assign ls_gnt      = lsGnt_q;
  assign ls_rvalid   = lsRvalid_q;
  assign ls_rdata    = lsRdata_q;
  assign ls_excpt    = lsExcpt_q;
  assign mem_addr    = memAddr_q;
  assign mem_data_in = memDataIn_q;
  assign mem_we      = memWe_q;

endmodule

// File: tb/tb_arm_mem_arbiter.sv
// Scoreboard bench for arm_mem_arbiter: drivers push expected grants/responses, monitors pop on DUT events.
// Runs one latency-1 instance for most scenarios and a latency-3 instance for the latency scenario.
module tb_arm_mem_arbiter;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic        excpt;
  } rsp_t;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [31:0] data;
  } we_t;

  logic clk = 1'b0;
  logic rstB;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // latency-1 instance signals
  logic        ifReq, ifGnt, ifRvalid, ifExcpt;
  logic [31:0] ifAddr, ifRdata;
  logic        lsReq, lsWe, lsGnt, lsRvalid, lsExcpt;
  logic [31:0] lsAddr, lsWdata, lsRdata;
  logic [31:0] memAddr, memDataIn, memDataOut;
  logic        memWe, memExcpt;

  // latency-3 instance signals
  logic        if3Req, if3Gnt, if3Rvalid, if3Excpt;
  logic [31:0] if3Addr, if3Rdata;
  logic        ls3Req, ls3We, ls3Gnt, ls3Rvalid, ls3Excpt;
  logic [31:0] ls3Addr, ls3Wdata, ls3Rdata;
  logic [31:0] mem3Addr, mem3DataIn, mem3DataOut;
  logic        mem3We, mem3Excpt;

  int   ifGntQ[$];
  int   lsGntQ[$];
  rsp_t ifRspQ[$];
  rsp_t lsRspQ[$];
  we_t  weQ[$];
  int   if3GntQ[$];
  int   ls3GntQ[$];
  rsp_t if3RspQ[$];
  rsp_t ls3RspQ[$];

  arm_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) dut (
    .clk(clk), .rst_b(rstB),
    .if_req(ifReq), .if_addr(ifAddr), .if_gnt(ifGnt), .if_rvalid(ifRvalid),
    .if_rdata(ifRdata), .if_excpt(ifExcpt),
    .ls_req(lsReq), .ls_we(lsWe), .ls_addr(lsAddr), .ls_wdata(lsWdata),
    .ls_gnt(lsGnt), .ls_rvalid(lsRvalid), .ls_rdata(lsRdata), .ls_excpt(lsExcpt),
    .mem_addr(memAddr), .mem_data_in(memDataIn), .mem_we(memWe),
    .mem_excpt(memExcpt), .mem_data_out(memDataOut)
  );

  arm_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3)) dut3 (
    .clk(clk), .rst_b(rstB),
    .if_req(if3Req), .if_addr(if3Addr), .if_gnt(if3Gnt), .if_rvalid(if3Rvalid),
    .if_rdata(if3Rdata), .if_excpt(if3Excpt),
    .ls_req(ls3Req), .ls_we(ls3We), .ls_addr(ls3Addr), .ls_wdata(ls3Wdata),
    .ls_gnt(ls3Gnt), .ls_rvalid(ls3Rvalid), .ls_rdata(ls3Rdata), .ls_excpt(ls3Excpt),
    .mem_addr(mem3Addr), .mem_data_in(mem3DataIn), .mem_we(mem3We),
    .mem_excpt(mem3Excpt), .mem_data_out(mem3DataOut)
  );

  // Memory model: unwritten word a reads 0x1000000a; address 7 raises an exception.
  logic [31:0] mem [0:15];
  logic [15:0] wrMask = '0;

  always @(posedge clk) begin
    if (memWe) begin
      mem[memAddr[3:0]]    <= memDataIn;
      wrMask[memAddr[3:0]] <= 1'b1;
    end
  end

  assign memDataOut  = wrMask[memAddr[3:0]] ? mem[memAddr[3:0]] : {28'h1000000, memAddr[3:0]};
  assign memExcpt    = (memAddr == 32'd7);
  assign mem3DataOut = {28'h1000000, mem3Addr[3:0]};
  assign mem3Excpt   = (mem3Addr == 32'd7);

  function automatic rsp_t mkRsp(input int c, input logic [31:0] d, input logic e);
    rsp_t r;
    r.cyc   = c;
    r.data  = d;
    r.excpt = e;
    return r;
  endfunction

  function automatic we_t mkWe(input int c, input logic [31:0] a, input logic [31:0] d);
    we_t w;
    w.cyc  = c;
    w.addr = a;
    w.data = d;
    return w;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic reportUnexpected(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s actual=1 required=0 (no expectation queued)", name);
  endtask

  // Monitor for the latency-1 instance
  always @(negedge clk) begin
    rsp_t r;
    we_t  w;
    if (ifGnt) begin
      if (ifGntQ.size() == 0) reportUnexpected("if_gnt");
      else checkOutput("if_gnt_cycle", cyc, ifGntQ.pop_front());
    end
    if (lsGnt) begin
      if (lsGntQ.size() == 0) reportUnexpected("ls_gnt");
      else checkOutput("ls_gnt_cycle", cyc, lsGntQ.pop_front());
    end
    if (ifRvalid) begin
      if (ifRspQ.size() == 0) reportUnexpected("if_rvalid");
      else begin
        r = ifRspQ.pop_front();
        checkOutput("if_rvalid_cycle", cyc, r.cyc);
        checkOutput("if_rdata", ifRdata, r.data);
        checkOutput("if_excpt", {31'd0, ifExcpt}, {31'd0, r.excpt});
      end
    end
    if (lsRvalid) begin
      if (lsRspQ.size() == 0) reportUnexpected("ls_rvalid");
      else begin
        r = lsRspQ.pop_front();
        checkOutput("ls_rvalid_cycle", cyc, r.cyc);
        checkOutput("ls_rdata", lsRdata, r.data);
        checkOutput("ls_excpt", {31'd0, lsExcpt}, {31'd0, r.excpt});
      end
    end
    if (memWe) begin
      if (weQ.size() == 0) reportUnexpected("mem_we");
      else begin
        w = weQ.pop_front();
        checkOutput("mem_we_cycle", cyc, w.cyc);
        checkOutput("mem_we_addr", memAddr, w.addr);
        checkOutput("mem_we_data", memDataIn, w.data);
      end
    end
  end

  // Monitor for the latency-3 instance
  always @(negedge clk) begin
    rsp_t r;
    if (if3Gnt) begin
      if (if3GntQ.size() == 0) reportUnexpected("lat3_if_gnt");
      else checkOutput("lat3_if_gnt_cycle", cyc, if3GntQ.pop_front());
    end
    if (ls3Gnt) begin
      if (ls3GntQ.size() == 0) reportUnexpected("lat3_ls_gnt");
      else checkOutput("lat3_ls_gnt_cycle", cyc, ls3GntQ.pop_front());
    end
    if (if3Rvalid) begin
      if (if3RspQ.size() == 0) reportUnexpected("lat3_if_rvalid");
      else begin
        r = if3RspQ.pop_front();
        checkOutput("lat3_if_rvalid_cycle", cyc, r.cyc);
        checkOutput("lat3_if_rdata", if3Rdata, r.data);
      end
    end
    if (ls3Rvalid) begin
      if (ls3RspQ.size() == 0) reportUnexpected("lat3_ls_rvalid");
      else begin
        r = ls3RspQ.pop_front();
        checkOutput("lat3_ls_rvalid_cycle", cyc, r.cyc);
        checkOutput("lat3_ls_rdata", ls3Rdata, r.data);
      end
    end
    if (mem3We) reportUnexpected("lat3_mem_we");
  end

  task automatic waitGnt(input bit isLs);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(isLs ? lsGnt : ifGnt) && k < 20);
    checks++;
    if (!(isLs ? lsGnt : ifGnt)) begin
      failures++;
      $display("[TB] FAIL gnt_timeout actual=0 required=1 (isLs=%0d)", isLs);
    end
  endtask

  // One uncontended access on the latency-1 instance: gnt N+1, rvalid N+2.
  task automatic applyStimulus(input bit isLs, input bit we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] expData,
                               input logic expExcpt);
    int n;
    @(posedge clk); #1;
    n = cyc;
    if (isLs) begin
      lsReq = 1'b1; lsWe = we; lsAddr = addr; lsWdata = wdata;
      lsGntQ.push_back(n + 1);
      lsRspQ.push_back(mkRsp(n + 2, expData, expExcpt));
      if (we) weQ.push_back(mkWe(n + 1, addr, wdata));
    end else begin
      ifReq = 1'b1; ifAddr = addr;
      ifGntQ.push_back(n + 1);
      ifRspQ.push_back(mkRsp(n + 2, expData, expExcpt));
    end
    waitGnt(isLs);
    @(posedge clk); #1;
    ifReq = 1'b0;
    lsReq = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rstB = 1'b0;
    ifReq = 1'b0; ifAddr = '0;
    lsReq = 1'b1; lsWe = 1'b0; lsAddr = 32'd1; lsWdata = '0;
    if3Req = 1'b0; if3Addr = '0;
    ls3Req = 1'b0; ls3We = 1'b0; ls3Addr = '0; ls3Wdata = '0;

    // Reset held with an LS request pending: everything stays quiet.
    repeat (3) @(posedge clk); #1;
    checkOutput("rst_ls_gnt", {31'd0, lsGnt}, 32'd0);
    checkOutput("rst_if_gnt", {31'd0, ifGnt}, 32'd0);
    checkOutput("rst_mem_we", {31'd0, memWe}, 32'd0);
    checkOutput("rst_mem_addr", memAddr, 32'd0);
    checkOutput("rst_mem_data_in", memDataIn, 32'd0);
    checkOutput("rst_ls_rvalid", {31'd0, lsRvalid}, 32'd0);
    checkOutput("rst_ls_rdata", lsRdata, 32'd0);
    checkOutput("rst_if_rdata", ifRdata, 32'd0);
    n = cyc;
    rstB = 1'b1;
    lsGntQ.push_back(n + 1);
    lsRspQ.push_back(mkRsp(n + 2, 32'h1000_0001, 1'b0));
    waitGnt(1'b1);
    @(posedge clk); #1;
    lsReq = 1'b0;
    repeat (2) @(posedge clk);

    // Write then read back through the fetch port.
    applyStimulus(1'b1, 1'b1, 32'd5, 32'hDEAD_BEEF, 32'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'd5, 32'd0, 32'hDEAD_BEEF, 1'b0);

    // Both requesters held across four accesses.
    @(posedge clk); #1;
    n = cyc;
    ifReq = 1'b1; ifAddr = 32'd2;
    lsReq = 1'b1; lsWe = 1'b0; lsAddr = 32'd3;
`ifdef ARM_MEM_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++) begin
      lsGntQ.push_back(n + 1 + 2 * i);
      lsRspQ.push_back(mkRsp(n + 2 + 2 * i, 32'h1000_0003, 1'b0));
    end
`else
    for (int i = 0; i < 2; i++) begin
      lsGntQ.push_back(n + 1 + 4 * i);
      lsRspQ.push_back(mkRsp(n + 2 + 4 * i, 32'h1000_0003, 1'b0));
      ifGntQ.push_back(n + 3 + 4 * i);
      ifRspQ.push_back(mkRsp(n + 4 + 4 * i, 32'h1000_0002, 1'b0));
    end
`endif
    repeat (8) @(posedge clk); #1;
    ifReq = 1'b0;
    lsReq = 1'b0;
    repeat (3) @(posedge clk);

    // LS read of the faulting address.
    applyStimulus(1'b1, 1'b0, 32'd7, 32'd0, 32'h1000_0007, 1'b1);

    // Latency 3: IF at N, LS raised at N+2 waits for the IDLE cycle N+4.
    @(posedge clk); #1;
    n = cyc;
    if3Req = 1'b1; if3Addr = 32'd6;
    if3GntQ.push_back(n + 1);
    if3RspQ.push_back(mkRsp(n + 4, 32'h1000_0006, 1'b0));
    @(posedge clk); #1;
    @(posedge clk); #1;
    if3Req = 1'b0;
    ls3Req = 1'b1; ls3We = 1'b0; ls3Addr = 32'd8;
    ls3GntQ.push_back(n + 5);
    ls3RspQ.push_back(mkRsp(n + 8, 32'h1000_0008, 1'b0));
    repeat (4) @(posedge clk); #1;
    ls3Req = 1'b0;
    repeat (4) @(posedge clk);

    // Reset pulse during an access: the in-flight read never completes.
    @(posedge clk); #1;
    n = cyc;
    ifReq = 1'b1; ifAddr = 32'd9;
    ifGntQ.push_back(n + 1);
    waitGnt(1'b0);
    #1;
    rstB = 1'b0;
    #1;
    checkOutput("midrst_if_gnt", {31'd0, ifGnt}, 32'd0);
    checkOutput("midrst_mem_addr", memAddr, 32'd0);
    @(posedge clk); #1;
    rstB = 1'b1;
    ifReq = 1'b0;
    repeat (5) @(posedge clk);
    applyStimulus(1'b0, 1'b0, 32'd4, 32'd0, 32'h1000_0004, 1'b0);
    repeat (3) @(posedge clk);

    checkOutput("pending_if_gnt", ifGntQ.size(), 32'd0);
    checkOutput("pending_ls_gnt", lsGntQ.size(), 32'd0);
    checkOutput("pending_if_rsp", ifRspQ.size(), 32'd0);
    checkOutput("pending_ls_rsp", lsRspQ.size(), 32'd0);
    checkOutput("pending_mem_we", weQ.size(), 32'd0);
    checkOutput("pending_lat3_if_gnt", if3GntQ.size(), 32'd0);
    checkOutput("pending_lat3_ls_gnt", ls3GntQ.size(), 32'd0);
    checkOutput("pending_lat3_if_rsp", if3RspQ.size(), 32'd0);
    checkOutput("pending_lat3_ls_rsp", ls3RspQ.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
